// File: rtl/bcd_to_bin_seq_pkg.sv
// bcd_to_bin_seq_pkg: shared state encoding and widths for decimal-entry conversion
package bcd_to_bin_seq_pkg;
  localparam int ACC_WIDTH = 10;
  localparam int DIGIT_WIDTH = 4;
  localparam logic [DIGIT_WIDTH-1:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC = 2'd1;
  localparam logic [1:0] FIN = 2'd2;
endpackage

// File: rtl/bcd_mac_step.sv
// bcd_mac_step: combinational acc*10 + digit via shift-add
// ports: acc_i current accumulator, digit_i BCD digit, acc_o next accumulator
module bcd_mac_step
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [ACC_WIDTH-1:0]   acc_i,
  input  logic [DIGIT_WIDTH-1:0] digit_i,
  output logic [ACC_WIDTH-1:0]   acc_o
);
  assign acc_o = (acc_i << 3) + (acc_i << 1) + ACC_WIDTH'(digit_i);
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential three-digit BCD to binary converter with saturation
// ports: clk_i clock, rst_i sync active-low reset, start_i request (IDLE only),
//   hund_i/tens_i/ones_i BCD digits, bin_o result, done_o completion pulse,
//   err_o digit or range error for last result, busy_o conversion in progress
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int OUT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DIGIT_WIDTH-1:0] hund_i,
  input  logic [DIGIT_WIDTH-1:0] tens_i,
  input  logic [DIGIT_WIDTH-1:0] ones_i,
  output logic [OUT_WIDTH-1:0]   bin_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   busy_o
);
  localparam logic [ACC_WIDTH:0] SAT_L = (ACC_WIDTH+1)'((1 << OUT_WIDTH) - 1);
  logic [1:0] state_q, state_d, idx_q, idx_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [DIGIT_WIDTH-1:0] hund_q, hund_d, tens_q, tens_d, ones_q, ones_d, digit;
  logic dig_err_q, dig_err_d, done_q, done_d, err_q, err_d, over;
  logic [OUT_WIDTH-1:0] bin_q, bin_d;
  assign digit = idx_q == 2'd2 ? hund_q : idx_q == 2'd1 ? tens_q : ones_q;
  assign over = {1'b0, acc_q} > SAT_L;
  bcd_mac_step u_mac (.acc_i(acc_q), .digit_i(digit), .acc_o(acc_next));
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    hund_d = hund_q;
    tens_d = tens_q;
    ones_d = ones_q;
    dig_err_d = dig_err_q;
    bin_d = bin_q;
    err_d = err_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        hund_d = hund_i;
        tens_d = tens_i;
        ones_d = ones_i;
        acc_d = '0;
        idx_d = 2'd2;
        dig_err_d = hund_i > BCD_MAX_DIGIT || tens_i > BCD_MAX_DIGIT || ones_i > BCD_MAX_DIGIT;
        state_d = dig_err_d ? FIN : ACC;
      end
    end else if (state_q == ACC) begin
      acc_d = acc_next;
      idx_d = idx_q - 2'd1;
      state_d = idx_q == 2'd0 ? FIN : ACC;
    end else begin
      bin_d = dig_err_q ? '0 : over ? '1 : OUT_WIDTH'(acc_q);
      err_d = dig_err_q || over;
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      hund_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
      dig_err_q <= 1'b0;
      bin_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      dig_err_q <= dig_err_d;
      bin_q <= bin_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
  assign bin_o = bin_q;
  assign err_o = err_q;
  assign done_o = done_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [3:0] h = '0, t = '0, o = '0;
  logic [7:0] bin;
  logic done, err, busy;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  bcd_to_bin_seq #(.OUT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .hund_i(h), .tens_i(t), .ones_i(o),
    .bin_o(bin), .done_o(done), .err_o(err), .busy_o(busy)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input logic [3:0] a, b, c, input int eb, ee, elat);
    int n;
    h = a; t = b; o = c; start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, "_busy"}, int'(busy), 1);
    n = 0;
    while (!done && n < 12) begin
      tick;
      n++;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_bin"}, int'(bin), eb);
    check({tag, "_err"}, int'(err), ee);
    check({tag, "_busy_done"}, int'(busy), 0);
    tick;
    check({tag, "_done_drop"}, int'(done), 0);
    check({tag, "_bin_hold"}, int'(bin), eb);
  endtask
  initial begin
    int cnt, first, last, cap;
    repeat (2) tick;
    check("rst_bin", int'(bin), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    tick;
    run("t123", 4'd1, 4'd2, 4'd3, 123, 0, 4);
    run("t255", 4'd2, 4'd5, 4'd5, 255, 0, 4);
    run("t256", 4'd2, 4'd5, 4'd6, 255, 1, 4);
    run("t999", 4'd9, 4'd9, 4'd9, 255, 1, 4);
    run("tzero", 4'd0, 4'd0, 4'd0, 0, 0, 4);
    run("tbad", 4'd0, 4'hA, 4'd0, 0, 1, 1);
    h = 4'd0; t = 4'd4; o = 4'd2; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    h = 4'd9; t = 4'd9; o = 4'd9; start = 1'b1;
    tick;
    start = 1'b0;
    cnt = 0; cap = -1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done) begin
        cnt++;
        cap = int'(bin);
      end
    end
    check("ign_done_cnt", cnt, 1);
    check("ign_bin", cap, 42);
    check("ign_err", int'(err), 0);
    h = 4'd1; t = 4'd0; o = 4'd0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    check("abort_bin", int'(bin), 0);
    check("abort_done", int'(done), 0);
    check("abort_err", int'(err), 0);
    check("abort_busy", int'(busy), 0);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    run("t007", 4'd0, 4'd0, 4'd7, 7, 0, 4);
    h = 4'd0; t = 4'd1; o = 4'd0; start = 1'b1;
    tick;
    cnt = 0; first = -1; last = -1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (done) begin
        cnt++;
        if (first < 0) first = i;
        else check("b2b_gap", i - last, 5);
        last = i;
        check("b2b_bin", int'(bin), 10);
      end
    end
    check("b2b_first", first, 4);
    check("b2b_cnt", cnt, 4);
    start = 1'b0;
    repeat (8) tick;
    check("b2b_idle", int'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
